// File: rtl/cardinal_interlock_unit.sv
// Hazard/interlock and WB->EX forwarding unit for the cardinal 4-stage pipeline.
// Multi-cycle EX ops stall by class latency; WB data is merged into EX operands per lane mask.
module cardinal_interlock_unit #(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int LD_LAT    = 2,
    parameter int MUL_LAT   = 2,
    parameter int ADD64_LAT = 2,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [1:0]        ex_class,
    input  logic              ex_kill,
    input  logic [REG_AW-1:0] ex_rs_a,
    input  logic [REG_AW-1:0] ex_rs_b,
    input  logic              ex_use_a,
    input  logic              ex_use_b,
    input  logic [DATA_W-1:0] opr_a_in,
    input  logic [DATA_W-1:0] opr_b_in,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [2:0]        wb_ppp,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_last,
    output logic [DATA_W-1:0] opr_a_out,
    output logic [DATA_W-1:0] opr_b_out,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int         H         = DATA_W / 2;
    localparam logic [3:0] LAT_LD    = 4'(LD_LAT);
    localparam logic [3:0] LAT_MUL   = 4'(MUL_LAT);
    localparam logic [3:0] LAT_ADD64 = 4'(ADD64_LAT);

    // Lane mask; positions are MSB-first, so msb-index j = DATA_W-1-i and byte j/8.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [2:0] ppp);
        logic [DATA_W-1:0] m;
        int                j;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            j = DATA_W - 1 - i;
            case (ppp)
                3'b000:  m[i] = 1'b1;
                3'b001:  m[i] = (j < H);
                3'b010:  m[i] = (j >= H);
                3'b011:  m[i] = ((j % 16) < 8);
                3'b100:  m[i] = ((j % 16) >= 8);
                default: m[i] = 1'b0;
            endcase
        end
        return m;
    endfunction

    logic [3:0]        r_cnt;
    logic [PERF_W-1:0] r_stall_cycles;
    logic [3:0]        w_lat;
    logic              w_stall;
    logic              w_ex_last;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_mask;

    // Latency lookup by EX instruction class.
    always_comb begin
        w_lat = 4'd1;
        case (ex_class)
            2'b00:   w_lat = 4'd1;
            2'b01:   w_lat = LAT_LD;
            2'b10:   w_lat = LAT_MUL;
            2'b11:   w_lat = LAT_ADD64;
            default: w_lat = 4'd1;
        endcase
    end

    // Stall until the occupancy counter reaches the final cycle; reset and kill suppress it.
    always_comb begin
        w_stall   = 1'b0;
        w_ex_last = 1'b0;
        if (reset) begin
            w_stall   = 1'b0;
            w_ex_last = 1'b0;
        end else begin
            w_stall   = ex_valid & ~ex_kill & (w_lat > 4'd1) & (r_cnt != (w_lat - 4'd1));
            w_ex_last = ex_valid & ~ex_kill & ~w_stall;
        end
    end

    // Occupancy counter: counts stalled cycles of the current op, returns to 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    // Saturating performance counter of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    // Forwarding hits; register 0 is hard-wired and never forwards.
    always_comb begin
        w_mask  = lane_mask(wb_ppp);
        w_hit_a = wb_wen & (wb_rd != '0) & (wb_rd == ex_rs_a) & ex_use_a;
        w_hit_b = wb_wen & (wb_rd != '0) & (wb_rd == ex_rs_b) & ex_use_b;
    end

    // Each operand merges WB lanes independently, even when both hit the same register.
    always_comb begin
        opr_a_out = opr_a_in;
        opr_b_out = opr_b_in;
        if (w_hit_a) begin
            opr_a_out = (wb_data & w_mask) | (opr_a_in & ~w_mask);
        end else begin
            opr_a_out = opr_a_in;
        end
        if (w_hit_b) begin
            opr_b_out = (wb_data & w_mask) | (opr_b_in & ~w_mask);
        end else begin
            opr_b_out = opr_b_in;
        end
    end

    assign stall        = w_stall;
    assign ex_last      = w_ex_last;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/cardinal_interlock_unit.md
Name: cardinal_interlock_unit

Overview:
- Parametrised hazard/interlock and EX-operand forwarding unit for the next-generation cardinal 4-stage pipeline (IF, ID, EX/MEM, WB).
- Replaces fixed one-cycle load/multiply stalling with per-class programmable multi-cycle EX occupancy.
- Generates sub-word (ppp lane-masked) forwarding from WB into the EX operands for any DATA_W.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 64: datapath width; must be a multiple of 16.
- REG_AW, 5: register address width.
- LD_LAT, 2: EX cycles occupied by a load/NIC load (1..15).
- MUL_LAT, 2: EX cycles occupied by a multiply (1..15).
- ADD64_LAT, 2: EX cycles occupied by a 64-bit add/sub (1..15).
- PERF_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  a non-NOP instruction is present in EX.
- ex_class  in  2  00 single-cycle, 01 load, 10 multiply, 11 64-bit add/sub.
- ex_kill  in  1  abort the in-flight EX op.
- ex_rs_a  in  REG_AW  EX source A register.
- ex_rs_b  in  REG_AW  EX source B register.
- ex_use_a  in  1  source A is read from the register file.
- ex_use_b  in  1  source B is read from the register file (0 for immediate ops).
- opr_a_in  in  DATA_W  ID/EX latched operand A.
- opr_b_in  in  DATA_W  ID/EX latched operand B.
- wb_wen  in  1  WB writes the register file.
- wb_rd  in  REG_AW  WB destination register.
- wb_ppp  in  3  WB partial-write field.
- wb_data  in  DATA_W  WB data.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/WB registers.
- ex_last  out  1  final EX cycle of the current op.
- opr_a_out  out  DATA_W  forwarded operand A.
- opr_b_out  out  DATA_W  forwarded operand B.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Bit numbering is MSB-first: bit 0 is the MSB.
- Latency lookup L(ex_class): 00 gives 1; 01 gives LD_LAT; 10 gives MUL_LAT; 11 gives ADD64_LAT.
- State:
  - 4-bit occupancy counter cnt.
  - stall_cycles register.
  - Reset (asynchronous) clears both to 0.
  - While reset is high, stall=0 and ex_last=0.
- Stall rule:
  - stall = ex_valid & ~ex_kill & (L>1) & (cnt != L-1). This is combinational from the current state.
  - ex_last = ex_valid & ~ex_kill & ~stall.
- Counter rule:
  - If stall, cnt <= cnt+1; otherwise cnt <= 0.
  - An op of latency L therefore holds EX for exactly L cycles, with stall high for the first L-1 cycles.
  - Back-to-back multi-cycle ops each pay their full latency, because cnt returns to 0 between them.
- ex_kill:
  - stall=0 in the kill cycle.
  - cnt <= 0.
  - Pipeline advances on the next edge.
  - A kill in the op's first EX cycle yields 0 stall cycles.
- ex_class change while stalled is illegal; the bench must not drive it.
- stall_cycles increments on every cycle with stall=1 and saturates at all ones (no wrap).
- Lane mask M from wb_ppp, H = DATA_W/2:
  - 000: all bits.
  - 001: bits 0..H-1.
  - 010: bits H..DATA_W-1.
  - 011: even bytes (bytes 0,2,4,...).
  - 100: odd bytes.
  - 101..111: no bits.
- Forwarding, per operand x in {a,b}:
  - hit_x = wb_wen & (wb_rd != 0) & (wb_rd == ex_rs_x) & ex_use_x.
  - opr_x_out = hit_x ? (wb_data & M) | (opr_x_in & ~M) : opr_x_in.
  - Purely combinational, zero latency.
- Forwarding stays active during stall cycles, because WB is frozen and holds its value.
- Register 0 never forwards.
- Both operands may hit the same WB register simultaneously; each is merged independently.

Test Plan:
- Reset mid-stall: MUL_LAT=4, cnt=2, assert reset → cnt=0, stall=0 and stall_cycles=0 immediately; after release with ex_class=10 still valid, the op restarts and stalls 3 cycles.
- Load with defaults: ex_valid=1, ex_class=01 → stall=1 for 1 cycle, then ex_last=1; stall_cycles=1.
- Multiply with MUL_LAT=4 followed immediately by a 64-bit add with ADD64_LAT=3 → stall pattern 1,1,1,0,1,1,0; stall_cycles=5.
- ex_kill in the second cycle of a MUL_LAT=4 op → stall drops that cycle and cnt=0 next cycle; stall_cycles=1.
- Forwarding: wb_ppp=001, wb_rd=3, wb_wen=1, wb_data=64'hAAAA_AAAA_5555_5555, opr_a_in=64'h1111_2222_3333_4444, ex_rs_a=3, ex_use_a=1 → opr_a_out=64'hAAAA_AAAA_3333_4444. Same setup with wb_ppp=011 → 64'hAA11_AA22_5533_5544.
- No forward: wb_rd=0, or ex_use_b=0, or wb_wen=0 → opr_b_out equals opr_b_in. Saturation with PERF_W=4: after 20 stall cycles, stall_cycles=4'hF.
